// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and the one-hot key encoder for the keypad front end.
package keypad_pkg;

  localparam int KP_NKEYS = 10;
  localparam logic [3:0] KEY_NONE = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    BLOCKED = 2'd2
  } key_state_t;

  // Index of the lowest set bit; KEY_NONE when no bit is set.
  function automatic logic [3:0] onehot_to_code(input logic [15:0] onehot);
    logic [3:0] code;
    code = KEY_NONE;
    for (int i = 15; i >= 0; i--) begin
      if (onehot[i]) code = 4'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input line: 2-flop synchroniser, optional polarity flip, and a stability counter
// that moves the debounced level only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter bit RAW_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  // A single-cycle debounce still needs one counter bit to hold the terminal value 0.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          s;
  logic [CW-1:0] cnt;

  // Polarity is fixed after the synchroniser so latency is identical either way.
  assign s = sync ^ RAW_ACTIVE_LOW;

  // Synchroniser and stability counter; any sample equal to deb restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (s == deb) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        deb <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_conditioner.sv
// Watch set-mode keypad front end: debounces NKEYS numpad lines plus the done button and
// qualifies key presses into single-cycle one-hot pulses, rejecting multi-key and repeat.
// Output strobes: key_valid is a 1-cycle strobe that coincides exactly with a nonzero
// key_pulse; done_pulse and multi_err are independent 1-cycle strobes. There is no
// back-pressure: the consumer must sample every cycle.
module keypad_conditioner
  import keypad_pkg::*;
#(
  parameter int NKEYS           = KP_NKEYS,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter bit RAW_ACTIVE_LOW  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_raw,
  input  logic             done_raw,
  output logic [NKEYS-1:0] key_pulse,
  output logic [3:0]       key_code,
  output logic             key_valid,
  output logic             key_held,
  output logic             done_pulse,
  output logic             multi_err,
  output key_state_t       fsm_state
);

  logic [NKEYS:0]   raw_all;
  logic [NKEYS:0]   deb_all;
  logic [NKEYS-1:0] deb_keys;
  logic             deb_done;
  logic             deb_done_q;

  key_state_t       state;
  key_state_t       state_n;
  logic [NKEYS-1:0] accepted;
  logic [NKEYS-1:0] accepted_n;
  logic [NKEYS-1:0] pulse_n;
  logic [3:0]       code_n;
  logic             valid_n;
  logic             err_n;
  logic             is_onehot;

  assign raw_all  = {done_raw, key_raw};
  assign deb_keys = deb_all[NKEYS-1:0];
  assign deb_done = deb_all[NKEYS];

  // Top bit of the vector is the done button; it gets the same conditioning as the keys.
  for (genvar g = 0; g <= NKEYS; g++) begin : g_line
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .raw(raw_all[g]),
      .deb(deb_all[g])
    );
  end

  assign is_onehot = (deb_keys != '0) && ((deb_keys & (deb_keys - NKEYS'(1))) == '0);
  assign key_held  = (state == HELD);
  assign fsm_state = state;

  // Next-state and next-output decode for key qualification.
  always_comb begin
    state_n    = state;
    accepted_n = accepted;
    pulse_n    = '0;
    code_n     = key_code;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (deb_keys != '0) begin
          if (is_onehot) begin
            state_n    = HELD;
            accepted_n = deb_keys;
            pulse_n    = deb_keys;
            valid_n    = 1'b1;
            code_n     = onehot_to_code(16'(deb_keys));
          end else begin
            state_n = BLOCKED;
            err_n   = 1'b1;
          end
        end
      end
      HELD: begin
        if (deb_keys == '0) begin
          state_n = IDLE;
          code_n  = KEY_NONE;
        end else if (deb_keys != accepted) begin
          state_n = BLOCKED;
          err_n   = 1'b1;
          code_n  = KEY_NONE;
        end
      end
      BLOCKED: begin
        if (deb_keys == '0) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        code_n  = KEY_NONE;
      end
    endcase
  end

  // State, accepted key and registered outputs; done edge detect runs beside the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      accepted   <= '0;
      key_pulse  <= '0;
      key_code   <= KEY_NONE;
      key_valid  <= 1'b0;
      multi_err  <= 1'b0;
      deb_done_q <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      accepted   <= accepted_n;
      key_pulse  <= pulse_n;
      key_code   <= code_n;
      key_valid  <= valid_n;
      multi_err  <= err_n;
      deb_done_q <= deb_done;
      done_pulse <= deb_done & ~deb_done_q;
    end
  end

endmodule

// File: tb/tb_keypad_conditioner.sv
// Bench for keypad_conditioner: two instances (20-cycle and 1-cycle debounce) share the
// same stimulus and are compared every cycle against a sample-history reference model.
module tb_keypad_conditioner;
  import keypad_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key_raw = '0;
  logic       done_raw = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] kp0, kp1;
  logic [3:0] kc0, kc1;
  logic       kv0, kv1, kh0, kh1, dp0, dp1, me0, me1;
  key_state_t st0, st1;

  keypad_conditioner #(.NKEYS(10), .DEBOUNCE_CYCLES(20), .RAW_ACTIVE_LOW(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .key_raw(key_raw), .done_raw(done_raw),
    .key_pulse(kp0), .key_code(kc0), .key_valid(kv0), .key_held(kh0),
    .done_pulse(dp0), .multi_err(me0), .fsm_state(st0)
  );

  keypad_conditioner #(.NKEYS(10), .DEBOUNCE_CYCLES(1), .RAW_ACTIVE_LOW(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .key_raw(key_raw), .done_raw(done_raw),
    .key_pulse(kp1), .key_code(kc1), .key_valid(kv1), .key_held(kh1),
    .done_pulse(dp1), .multi_err(me1), .fsm_state(st1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A line's debounced level follows its synchronised sample once that sample has been
  // the same for dc consecutive clocks. Keys: a lone key press is accepted once; anything
  // else pressed at the same time locks the pad out until everything is released.
  int   dc_of[2] = '{20, 1};
  bit   m_sync1[2][11];
  bit   m_s[2][11];
  bit   m_deb[2][11];
  int   m_run[2][11];
  bit   m_done_q[2];
  int   m_held[2];
  bit   m_blk[2];
  logic [9:0] e_pulse[2];
  logic [3:0] e_code[2];
  logic e_valid[2], e_held[2], e_done[2], e_err[2];

  task automatic model_step(input int u);
    logic [9:0]  d;
    logic [10:0] raw_all;
    raw_all = {done_raw, key_raw};
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        m_sync1[u][i] = 0; m_s[u][i] = 0; m_deb[u][i] = 0; m_run[u][i] = 0;
      end
      m_done_q[u] = 0; m_held[u] = -1; m_blk[u] = 0;
      e_pulse[u] = '0; e_code[u] = 4'd15; e_valid[u] = 0;
      e_held[u] = 0; e_done[u] = 0; e_err[u] = 0;
    end else begin
      for (int i = 0; i < 10; i++) d[i] = m_deb[u][i];
      e_pulse[u] = '0; e_valid[u] = 0; e_err[u] = 0;
      if (m_blk[u]) begin
        if (d == 0) m_blk[u] = 0;
      end else if (m_held[u] >= 0) begin
        if (d == 0) begin
          m_held[u] = -1; e_code[u] = 4'd15;
        end else if (d != (10'd1 << m_held[u])) begin
          m_held[u] = -1; m_blk[u] = 1; e_err[u] = 1; e_code[u] = 4'd15;
        end
      end else if (d != 0) begin
        if ($countones(d) == 1) begin
          for (int i = 0; i < 10; i++) if (d[i]) m_held[u] = i;
          e_pulse[u] = d; e_valid[u] = 1; e_code[u] = 4'(m_held[u]);
          if (u == 0) exp_q.push_back(d);
        end else begin
          m_blk[u] = 1; e_err[u] = 1;
        end
      end
      e_held[u]   = (m_held[u] >= 0);
      e_done[u]   = m_deb[u][10] & ~m_done_q[u];
      m_done_q[u] = m_deb[u][10];
      for (int i = 0; i < 11; i++) begin
        if (m_s[u][i] != m_deb[u][i] && m_run[u][i] >= dc_of[u]) m_deb[u][i] = m_s[u][i];
        if (m_sync1[u][i] == m_s[u][i]) begin
          if (m_run[u][i] < 1000) m_run[u][i]++;
        end else begin
          m_run[u][i] = 1;
        end
        m_s[u][i]     = m_sync1[u][i];
        m_sync1[u][i] = raw_all[i];
      end
    end
  endtask

  // Model advances on every active edge, with the inputs the DUT sees.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Lockstep comparison of both instances, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      logic [9:0] want;
      check("u0_key_pulse",  kp0, e_pulse[0]);
      check("u0_key_code",   kc0, e_code[0]);
      check("u0_key_valid",  kv0, e_valid[0]);
      check("u0_key_held",   kh0, e_held[0]);
      check("u0_done_pulse", dp0, e_done[0]);
      check("u0_multi_err",  me0, e_err[0]);
      check("u1_key_pulse",  kp1, e_pulse[1]);
      check("u1_key_code",   kc1, e_code[1]);
      check("u1_key_valid",  kv1, e_valid[1]);
      check("u1_key_held",   kh1, e_held[1]);
      check("u1_done_pulse", dp1, e_done[1]);
      check("u1_multi_err",  me1, e_err[1]);
      if (kv0) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h000;
        check("sb_pulse", kp0, want);
      end
    end
  end

  // ---------------- driver tasks ----------------
  int first_valid[2], first_err[2], first_done[2], first_unheld[2];
  int n_valid[2], n_err[2], n_done[2];

  task automatic drive(input logic [9:0] k, input logic d);
    @(negedge clk);
    key_raw  = k;
    done_raw = d;
  endtask

  // Observe ncyc active edges; edge 0 is the first edge after the last drive.
  task automatic watch(input int ncyc);
    for (int u = 0; u < 2; u++) begin
      first_valid[u] = -1; first_err[u] = -1; first_done[u] = -1; first_unheld[u] = -1;
      n_valid[u] = 0; n_err[u] = 0; n_done[u] = 0;
    end
    for (int e = 0; e < ncyc; e++) begin
      @(posedge clk);
      #1;
      if (kv0) begin n_valid[0]++; if (first_valid[0] < 0) first_valid[0] = e; end
      if (kv1) begin n_valid[1]++; if (first_valid[1] < 0) first_valid[1] = e; end
      if (me0) begin n_err[0]++;   if (first_err[0] < 0)   first_err[0] = e;   end
      if (me1) begin n_err[1]++;   if (first_err[1] < 0)   first_err[1] = e;   end
      if (dp0) begin n_done[0]++;  if (first_done[0] < 0)  first_done[0] = e;  end
      if (dp1) begin n_done[1]++;  if (first_done[1] < 0)  first_done[1] = e;  end
      if (!kh0 && first_unheld[0] < 0) first_unheld[0] = e;
      if (!kh1 && first_unheld[1] < 0) first_unheld[1] = e;
    end
  endtask

  task automatic report;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int total;
    logic [9:0] k;
    logic d;
    int r;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    check("reset_code", kc0, 4'd15);
    check("reset_pulse", kp0, 10'h000);
    check("reset_held", kh0, 1'b0);
    rst = 1'b0;
    watch(5);

    // 1: clean press of key 7, then release
    drive(10'h080, 1'b0); watch(100);
    check("s1_latency_u0", first_valid[0], 22);
    check("s1_latency_u1", first_valid[1], 3);
    check("s1_count_u0", n_valid[0], 1);
    drive(10'h000, 1'b0); watch(40);
    check("s1_release_u0", first_unheld[0], 22);
    check("s1_release_u1", first_unheld[1], 3);

    // 2: bouncy press of key 3, then bouncy release
    total = 0;
    for (int t = 0; t < 12; t++) begin
      drive((t % 2 == 0) ? 10'h008 : 10'h000, 1'b0); watch(5);
      total += n_valid[0];
    end
    check("s2_bounce_pulses", total, 0);
    drive(10'h008, 1'b0); watch(60);
    check("s2_latency_u0", first_valid[0], 22);
    check("s2_count_u0", n_valid[0], 1);
    total = 0;
    for (int t = 0; t < 8; t++) begin
      drive((t % 2 == 0) ? 10'h000 : 10'h008, 1'b0); watch(5);
      total += n_valid[0];
    end
    drive(10'h000, 1'b0); watch(40);
    check("s2_release_pulses", total + n_valid[0], 0);

    // 3: key 2 held, key 5 added, partial then full release
    drive(10'h004, 1'b0); watch(50);
    check("s3_first_pulse", n_valid[0], 1);
    drive(10'h024, 1'b0); watch(60);
    check("s3_err_latency", first_err[0], 22);
    check("s3_no_pulse", n_valid[0], 0);
    drive(10'h004, 1'b0); watch(40);
    check("s3_partial_release", n_valid[0], 0);
    drive(10'h000, 1'b0); watch(40);
    check("s3_code_idle", kc0, 4'd15);
    check("s3_held_idle", kh0, 1'b0);

    // 4: two keys on the same cycle
    drive(10'h202, 1'b0); watch(40);
    check("s4_err_latency", first_err[0], 22);
    check("s4_err_latency_u1", first_err[1], 3);
    check("s4_no_pulse", n_valid[0], 0);
    drive(10'h000, 1'b0); watch(40);

    // 5: done and key 0 together
    drive(10'h001, 1'b1); watch(40);
    check("s5_done_u0", first_done[0], 22);
    check("s5_key_u0", first_valid[0], 22);
    check("s5_done_u1", first_done[1], 3);
    check("s5_key_u1", first_valid[1], 3);
    drive(10'h000, 1'b0); watch(40);
    check("s5_no_done_on_release", n_done[0], 0);

    // 6: reset in the middle of a held press of key 4
    drive(10'h010, 1'b0); watch(30);
    @(negedge clk); rst = 1'b1;
    watch(2);
    check("s6_rst_code", kc0, 4'd15);
    check("s6_rst_held", kh0, 1'b0);
    @(negedge clk); rst = 1'b0;
    watch(40);
    check("s6_fresh_u0", first_valid[0], 22);
    check("s6_fresh_u1", first_valid[1], 3);
    check("s6_count_u0", n_valid[0], 1);
    drive(10'h000, 1'b0); watch(40);

    // Random phase: single keys, idle gaps, multi-key chords, bounce and resets
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        @(negedge clk); rst = 1'b1;
        watch($urandom_range(1, 3));
        @(negedge clk); rst = 1'b0;
      end else begin
        if (r < 12)      k = 10'd1 << $urandom_range(0, 9);
        else if (r < 16) k = 10'h000;
        else             k = 10'($urandom()) & 10'($urandom());
        d = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) begin
          for (int j = 0; j < $urandom_range(1, 6); j++) begin
            drive((j % 2 == 0) ? k : 10'h000, ~d); watch($urandom_range(1, 8));
          end
        end
        drive(k, d); watch($urandom_range(1, 60));
      end
    end

    drive(10'h000, 1'b0); watch(50);
    check("sb_drain", exp_q.size(), 0);
    report();
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #900000;
    n_fail++;
    $display("FAIL timeout t=%0t got=running expected=finished", $time);
    report();
    $finish;
  end

endmodule
